wide_lookup_table: RTL and testbench

Single-clock writeable look-up table with a narrow update port and a wide, pipelined lookup port. Each lookup returns RATIO consecutive update words in one beat. Adds three things: hardware self-initialisation after reset or on command, byte-enabled updates, and valid/ready flow control with backpressure on the lookup output. It sits between the host register path (update side) and the datapath consumer (lookup side) in the same clock domain.

---
 rtl/wide_lookup_table.sv | 197 +++++++++++++++++++
 tb/tb_wide_lookup_table.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_lookup_table.sv
// Purpose: writeable lookup table with a narrow byte-enabled update port and a wide lookup port,
//          plus hardware self-initialisation after reset or on init_start.
// Latency: update read 1 cycle; lookup accept at T gives lkp_dout_valid at T+2 at the earliest.
// Backpressure: lkp_ready drops once 3 lookups are outstanding; lkp_dout is held while
//               lkp_dout_valid & ~lkp_dout_ready. Both request sides are stalled while init_busy.
// Ports: clk/rst_n; init_start/init_busy; upd_* narrow host read/write port (lane = low addr bits,
//        row = high addr bits); lkp_* row lookup request/result with valid/ready on both sides.
module wide_lookup_table #(
    parameter int UPD_DEPTH     = 1024,
    parameter int UPD_DATA_BITS = 32,
    parameter int LKP_DATA_BITS = 128,
    parameter logic [UPD_DATA_BITS-1:0] INIT_VALUE = 32'hDEADBEEF,
    localparam int RATIO = LKP_DATA_BITS / UPD_DATA_BITS,
    localparam int UA    = $clog2(UPD_DEPTH),
    localparam int LW    = $clog2(RATIO),
    localparam int LA    = UA - LW,
    localparam int BE    = UPD_DATA_BITS / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init_start,
    output logic                     init_busy,
    input  logic                     upd_valid,
    output logic                     upd_ready,
    input  logic                     upd_we,
    input  logic [UA-1:0]            upd_addr,
    input  logic [BE-1:0]            upd_be,
    input  logic [UPD_DATA_BITS-1:0] upd_din,
    output logic                     upd_rvalid,
    output logic [UPD_DATA_BITS-1:0] upd_dout,
    input  logic                     lkp_valid,
    output logic                     lkp_ready,
    input  logic [LA-1:0]            lkp_addr,
    output logic                     lkp_dout_valid,
    input  logic                     lkp_dout_ready,
    output logic [LKP_DATA_BITS-1:0] lkp_dout
);

    localparam int ROWS = 1 << LA;
    localparam int LWI  = (LW > 0) ? LW : 1;

    typedef enum logic {IDLE = 1'b0, INIT = 1'b1} state_t;

    // One RAM block per lane; a lookup reads the same row from every lane.
    logic [UPD_DATA_BITS-1:0] mem [RATIO][ROWS];

    state_t          state, state_nxt;
    logic            init_pend;
    logic [LA-1:0]   init_row;

    logic [LWI-1:0]  upd_lane;
    logic [LA-1:0]   upd_row;
    logic            upd_acc, upd_wr, upd_rd;

    logic                     lkp_acc, lkp_del;
    logic [LKP_DATA_BITS-1:0] lkp_row;
    logic                     s1_vld;
    logic [LKP_DATA_BITS-1:0] s1_dat;
    logic [1:0]               outst;

    logic [LKP_DATA_BITS-1:0] ob_dat [3];
    logic [1:0]               ob_rd_ptr, ob_wr_ptr, ob_cnt;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // ---------------- init FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            init_pend <= 1'b1;
        end else begin
            state     <= state_nxt;
            // The pending flag only has to survive the first clock after reset.
            init_pend <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (init_pend || init_start) state_nxt = INIT;
            INIT: if (init_row == {LA{1'b1}}) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        init_busy = (state == INIT);
    end

    // Row counter wraps back to zero on the last INIT cycle, so every INIT starts at row 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         init_row <= '0;
        else if (init_busy) init_row <= init_row + 1'b1;
        else                init_row <= '0;
    end

    // ---------------- update port ----------------
    generate
        if (LW > 0) begin : g_lane
            assign upd_lane = upd_addr[LW-1:0];
        end else begin : g_nolane
            assign upd_lane = '0;
        end
    endgenerate

    assign upd_row   = upd_addr[UA-1 -: LA];
    assign upd_ready = ~init_busy;
    assign upd_acc   = upd_valid & upd_ready;
    assign upd_wr    = upd_acc & upd_we;
    assign upd_rd    = upd_acc & ~upd_we;

    // INIT and host writes are mutually exclusive because upd_ready is low during INIT.
    always_ff @(posedge clk) begin
        for (int l = 0; l < RATIO; l++) begin
            if (init_busy) begin
                mem[l][init_row] <= INIT_VALUE;
            end else if (upd_wr && upd_lane == LWI'(l)) begin
                for (int b = 0; b < BE; b++) begin
                    if (upd_be[b]) mem[l][upd_row][8*b +: 8] <= upd_din[8*b +: 8];
                end
            end
        end
    end

    // Sampled at the same edge as any write, so a read sees the pre-write word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_rvalid <= 1'b0;
            upd_dout   <= '0;
        end else begin
            upd_rvalid <= upd_rd;
            if (upd_rd) upd_dout <= mem[upd_lane][upd_row];
        end
    end

    // ---------------- lookup port ----------------
    assign lkp_ready      = ~init_busy & (outst != 2'd3);
    assign lkp_acc        = lkp_valid & lkp_ready;
    assign lkp_dout_valid = (ob_cnt != 2'd0);
    assign lkp_del        = lkp_dout_valid & lkp_dout_ready;
    assign lkp_dout       = ob_dat[ob_rd_ptr];

    always_comb begin
        lkp_row = '0;
        for (int l = 0; l < RATIO; l++) begin
            lkp_row[l*UPD_DATA_BITS +: UPD_DATA_BITS] = mem[l][lkp_addr];
        end
    end

    // RAM read stage: captured at the accept edge, so writes accepted in that cycle are not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= lkp_acc;
            if (lkp_acc) s1_dat <= lkp_row;
        end
    end

    // Outstanding count bounds s1 + buffer occupancy to 3, so a push never finds the buffer full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst <= 2'd0;
        end else begin
            case ({lkp_acc, lkp_del})
                2'b10:   outst <= outst + 2'd1;
                2'b01:   outst <= outst - 2'd1;
                default: outst <= outst;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ob_rd_ptr <= 2'd0;
            ob_wr_ptr <= 2'd0;
            ob_cnt    <= 2'd0;
            for (int i = 0; i < 3; i++) ob_dat[i] <= '0;
        end else begin
            if (s1_vld) begin
                ob_dat[ob_wr_ptr] <= s1_dat;
                ob_wr_ptr         <= inc3(ob_wr_ptr);
            end
            if (lkp_del) ob_rd_ptr <= inc3(ob_rd_ptr);
            case ({s1_vld, lkp_del})
                2'b10:   ob_cnt <= ob_cnt + 2'd1;
                2'b01:   ob_cnt <= ob_cnt - 2'd1;
                default: ob_cnt <= ob_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_lookup_table.sv
module tb_wide_lookup_table;

    localparam int W     = 32;
    localparam int LW    = 128;
    localparam int RATIO = 4;
    localparam int UA    = 10;
    localparam int LA    = 8;
    localparam int ROWS  = 256;
    localparam logic [31:0] INIT_V = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          init_start;
    logic          init_busy;
    logic          upd_valid, upd_ready, upd_we;
    logic [UA-1:0] upd_addr;
    logic [3:0]    upd_be;
    logic [W-1:0]  upd_din;
    logic          upd_rvalid;
    logic [W-1:0]  upd_dout;
    logic          lkp_valid, lkp_ready;
    logic [LA-1:0] lkp_addr;
    logic          lkp_dout_valid, lkp_dout_ready;
    logic [LW-1:0] lkp_dout;

    wide_lookup_table dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .init_start     (init_start),
        .init_busy      (init_busy),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_we         (upd_we),
        .upd_addr       (upd_addr),
        .upd_be         (upd_be),
        .upd_din        (upd_din),
        .upd_rvalid     (upd_rvalid),
        .upd_dout       (upd_dout),
        .lkp_valid      (lkp_valid),
        .lkp_ready      (lkp_ready),
        .lkp_addr       (lkp_addr),
        .lkp_dout_valid (lkp_dout_valid),
        .lkp_dout_ready (lkp_dout_ready),
        .lkp_dout       (lkp_dout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0]  model [1 << UA];
    logic [LW-1:0] lkp_q [$];
    logic [W-1:0]  upd_q [$];
    logic          exp_rv   = 1'b0;
    logic          busy_prev = 1'b0;
    logic          hold_vld = 1'b0;
    logic [LW-1:0] hold_dat = '0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] model_row(input logic [LA-1:0] r);
        logic [LW-1:0] v;
        v = '0;
        for (int l = 0; l < RATIO; l++) v[l*W +: W] = model[{r, 2'(l)}];
        return v;
    endfunction

    // Scoreboard: expectations are pushed at the handshake, compared when results appear.
    always @(negedge clk) begin
        if (!rst_n) begin
            lkp_q.delete();
            upd_q.delete();
            exp_rv    = 1'b0;
            busy_prev = 1'b0;
            hold_vld  = 1'b0;
        end else begin
            if (init_busy && !busy_prev)
                for (int i = 0; i < (1 << UA); i++) model[i] = INIT_V;
            busy_prev = init_busy;

            if (exp_rv || upd_rvalid) begin
                check("upd_rvalid", LW'(upd_rvalid), LW'(exp_rv));
                if (upd_rvalid && upd_q.size() > 0) check("upd_dout", LW'(upd_dout), LW'(upd_q.pop_front()));
            end
            exp_rv = 1'b0;

            if (hold_vld) begin
                check("lkp_hold_vld", LW'(lkp_dout_valid), LW'(1));
                check("lkp_hold_dat", lkp_dout, hold_dat);
            end
            hold_vld = lkp_dout_valid & ~lkp_dout_ready;
            hold_dat = lkp_dout;

            if (lkp_dout_valid && lkp_dout_ready) begin
                if (lkp_q.size() > 0) check("lkp_dout", lkp_dout, lkp_q.pop_front());
                else                  check("lkp_unexpected", LW'(1), LW'(0));
            end

            if (lkp_valid && lkp_ready) lkp_q.push_back(model_row(lkp_addr));

            if (upd_valid && upd_ready) begin
                if (upd_we) begin
                    for (int b = 0; b < 4; b++)
                        if (upd_be[b]) model[upd_addr][8*b +: 8] = upd_din[8*b +: 8];
                end else begin
                    upd_q.push_back(model[upd_addr]);
                    exp_rv = 1'b1;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic measure_init(output int n);
        n = 0;
        for (int i = 0; i < 2*ROWS + 20; i++) begin
            @(negedge clk);
            if (init_busy) begin
                if (n == 0) begin
                    check("init_upd_ready", LW'(upd_ready), LW'(0));
                    check("init_lkp_ready", LW'(lkp_ready), LW'(0));
                end
                n++;
            end else if (n > 0) begin
                break;
            end
        end
    endtask

    task automatic upd_op(input logic we, input logic [UA-1:0] a, input logic [3:0] be, input logic [W-1:0] d);
        int n;
        upd_valid = 1'b1; upd_we = we; upd_addr = a; upd_be = be; upd_din = d;
        n = 0;
        while (!upd_ready && n < 600) begin step(); n++; end
        if (n == 600) check("upd_wait", LW'(0), LW'(1));
        step();
        upd_valid = 1'b0; upd_we = 1'b0;
    endtask

    task automatic lkp_send(input logic [LA-1:0] a);
        int n;
        lkp_valid = 1'b1; lkp_addr = a;
        n = 0;
        while (!lkp_ready && n < 600) begin step(); n++; end
        if (n == 600) check("lkp_wait", LW'(0), LW'(1));
        step();
        lkp_valid = 1'b0;
    endtask

    // Exact-latency lookup on an empty pipeline: valid must appear two cycles after accept.
    task automatic lkp_lat(input logic [LA-1:0] a);
        lkp_valid = 1'b1; lkp_addr = a;
        @(negedge clk);
        check("lat_ready", LW'(lkp_ready), LW'(1));
        step();
        lkp_valid = 1'b0;
        @(negedge clk);
        check("lat_t1_valid", LW'(lkp_dout_valid), LW'(0));
        step();
        @(negedge clk);
        check("lat_t2_valid", LW'(lkp_dout_valid), LW'(1));
        step();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && (lkp_q.size() != 0 || upd_q.size() != 0); i++) step();
    endtask

    initial begin
        int n;
        int stall;
        rst_n = 1'b0; init_start = 1'b0;
        upd_valid = 1'b0; upd_we = 1'b0; upd_addr = '0; upd_be = '0; upd_din = '0;
        lkp_valid = 1'b0; lkp_addr = '0; lkp_dout_ready = 1'b1;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_init_busy",  LW'(init_busy), LW'(0));
        check("rst_upd_ready",  LW'(upd_ready), LW'(1));
        check("rst_lkp_ready",  LW'(lkp_ready), LW'(1));
        check("rst_upd_rvalid", LW'(upd_rvalid), LW'(0));
        check("rst_upd_dout",   LW'(upd_dout), LW'(0));
        check("rst_lkp_vld",    LW'(lkp_dout_valid), LW'(0));
        check("rst_lkp_dout",   lkp_dout, LW'(0));
        step();
        rst_n = 1'b1;

        measure_init(n);
        check("init_len_por", LW'(n), LW'(ROWS));
        step();

        // First and last row after power-on INIT, with latency.
        lkp_lat(LA'(0));
        lkp_lat(LA'(ROWS - 1));

        // Full-word write, then lookup of the containing row and an update read.
        upd_op(1'b1, UA'(5), 4'hF, 32'h11223344);
        lkp_send(LA'(1));
        upd_op(1'b0, UA'(5), 4'h0, 32'h0);

        // Same-cycle write and lookup to row 7: old data, then new data one cycle later.
        upd_valid = 1'b1; upd_we = 1'b1; upd_addr = UA'(7*4 + 2); upd_be = 4'hF; upd_din = 32'hCAFEF00D;
        lkp_valid = 1'b1; lkp_addr = LA'(7);
        check("rw_ready", LW'({upd_ready, lkp_ready}), LW'(2'b11));
        step();
        upd_valid = 1'b0; upd_we = 1'b0;
        step();
        lkp_valid = 1'b0;
        wait_drain();

        // Backpressure: only three lookups accepted, then in-order drain on consecutive cycles.
        lkp_dout_ready = 1'b0;
        lkp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lkp_addr = LA'(2 + i);
            check("bp_accept", LW'(lkp_ready), LW'(1));
            step();
        end
        lkp_addr = LA'(5);
        repeat (4) step();
        check("bp_full", LW'(lkp_ready), LW'(0));
        lkp_valid = 1'b0;
        lkp_dout_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_drain_vld", LW'(lkp_dout_valid), LW'(1));
            step();
        end
        lkp_send(LA'(5));
        lkp_send(LA'(6));
        wait_drain();

        // init_start with two lookups outstanding: they drain with pre-init data during INIT.
        lkp_dout_ready = 1'b0;
        lkp_send(LA'(1));
        lkp_send(LA'(7));
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        lkp_dout_ready = 1'b1;
        measure_init(n);
        check("init_len_cmd", LW'(n), LW'(ROWS));
        step();
        check("init_drained", LW'(lkp_q.size()), LW'(0));

        // Back-to-back sweep of every row: sustained one lookup per cycle.
        stall = 0;
        lkp_valid = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            lkp_addr = LA'(r);
            if (!lkp_ready) stall++;
            step();
        end
        lkp_valid = 1'b0;
        check("sweep_stall", LW'(stall), LW'(0));
        wait_drain();

        // Byte-enabled write over INIT_VALUE.
        upd_op(1'b1, UA'(5), 4'b0101, 32'hAABBCCDD);
        upd_op(1'b0, UA'(5), 4'h0, 32'h0);
        lkp_send(LA'(1));
        wait_drain();

        // Reset in the middle of INIT restarts a full INIT.
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        repeat (50) step();
        rst_n = 1'b0;
        step();
        step();
        @(negedge clk);
        check("mid_rst_busy",    LW'(init_busy), LW'(0));
        check("mid_rst_upd_rdy", LW'(upd_ready), LW'(1));
        check("mid_rst_lkp_vld", LW'(lkp_dout_valid), LW'(0));
        step();
        rst_n = 1'b1;
        measure_init(n);
        check("init_len_rst", LW'(n), LW'(ROWS));
        step();
        lkp_send(LA'(1));
        upd_op(1'b0, UA'(5), 4'h0, 32'h0);

        wait_drain();
        repeat (3) step();
        check("lkp_q_empty", LW'(lkp_q.size()), LW'(0));
        check("upd_q_empty", LW'(upd_q.size()), LW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
